// File: rtl/mult_controller_taint1.sv
// mult_controller_taint1: shift-add sequencing controller for a 1-bit
// taint-tracked sequential multiplier datapath.
//
// `MULT_CONST_TIME_EN` selects the schedule:
//   defined   - every multiplier bit gets an ADD and a SHIFT cycle. Latency
//               does not depend on the operand, and the operand taint never
//               enters ctrl_t.
//   undefined - the ADD cycle is skipped for zero multiplier bits. Each
//               skip/no-skip decision ORs multiplierReg_t into ctrl_t, because
//               the operation timing then depends on the multiplier value.
//
// All strobes are combinational decodes of the registered state. rsload also
// depends on the selected multiplier bit.
module mult_controller_taint1 #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic             multiplierReg_t,
  output logic             ready,
  output logic             done,
  output logic             done_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             mdld,
  output logic             mdld_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic [2:0]       state_dbg
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ctrl_t_q, ctrl_t_d;
  logic [IW-1:0] idx_nxt_s;
  logic          mr_bit_s;

  assign idx_nxt_s = idx_q + IW'(1);
  assign mr_bit_s  = multiplierReg[idx_q];

  // Next-state logic: walk the multiplier bits LSB first and stop after bit WIDTH-1.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ctrl_t_d = ctrl_t_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          idx_d    = '0;
          ctrl_t_d = start_t;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD: begin
`ifdef MULT_CONST_TIME_EN
        state_d  = S_ADD;
`else
        // Skipping ADD leaks bit 0 through timing, so the operand taint is absorbed.
        state_d  = mr_bit_s ? S_ADD : S_SHIFT;
        ctrl_t_d = ctrl_t_q | multiplierReg_t;
`endif
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Test for the last bit before incrementing, so idx never wraps.
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_nxt_s;
`ifdef MULT_CONST_TIME_EN
          state_d  = S_ADD;
`else
          state_d  = multiplierReg[idx_nxt_s] ? S_ADD : S_SHIFT;
          ctrl_t_d = ctrl_t_q | multiplierReg_t;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, bit index and control taint registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ctrl_t_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ctrl_t_q <= ctrl_t_d;
    end
  end

  // Output decode: one strobe group per state. Every taint follows ctrl_t, and rsload_t also carries the operand taint in ADD.
  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    mrld      = 1'b0;
    mdld      = 1'b0;
    rsclear   = 1'b0;
    rsload    = 1'b0;
    rsshr     = 1'b0;
    done_t    = ctrl_t_q;
    mrld_t    = ctrl_t_q;
    mdld_t    = ctrl_t_q;
    rsclear_t = ctrl_t_q;
    rsload_t  = ctrl_t_q;
    rsshr_t   = ctrl_t_q;
    state_dbg = state_q;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
      end
      S_LOAD: begin
        mrld    = 1'b1;
        mdld    = 1'b1;
        rsclear = 1'b1;
      end
      S_ADD: begin
        rsload   = mr_bit_s;
        rsload_t = ctrl_t_q | multiplierReg_t;
      end
      S_SHIFT: begin
        rsshr = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_controller_taint1.sv
// Self-checking bench for mult_controller_taint1 (WIDTH=4).
// A small shift-add datapath model is driven by the DUT strobes. Expected
// product, latency, done taint and add count are pushed when an operation
// starts and compared when done pulses.
module tb_mult_controller_taint1;

  localparam int W = 4;
`ifdef MULT_CONST_TIME_EN
  localparam bit CONST_T = 1'b1;
`else
  localparam bit CONST_T = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, start_t, mr_t;
  logic [W-1:0] mr_in, md_in;
  logic ready, done, done_t, mrld, mrld_t, mdld, mdld_t;
  logic rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t;
  logic [2:0] state_dbg;

  mult_controller_taint1 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
    .multiplierReg(mr_in), .multiplierReg_t(mr_t),
    .ready(ready), .done(done), .done_t(done_t),
    .mrld(mrld), .mrld_t(mrld_t), .mdld(mdld), .mdld_t(mdld_t),
    .rsclear(rsclear), .rsclear_t(rsclear_t), .rsload(rsload), .rsload_t(rsload_t),
    .rsshr(rsshr), .rsshr_t(rsshr_t), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    int             lat;
    logic           dt;
    int             pop;
  } exp_t;

  exp_t sb[$];
  exp_t e_push, e_pop;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   lat_cnt = 0;
  int   add_cnt = 0;
  int   accepts = 0;
  int   held_n = 0;
  int   last_done_cyc = 0;
  logic held = 1'b0;
  logic cur_st = 1'b0;
  logic cur_mt = 1'b0;
  logic ctrl_exp;
  logic [2*W:0]   rs = '0;
  logic [W-1:0]   md_reg = '0;
  logic [2*W-1:0] p_a, p_b;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] out_vec();
    return {ready, done, done_t, mrld, mrld_t, mdld, mdld_t, rsclear, rsclear_t,
            rsload, rsload_t, rsshr, rsshr_t, state_dbg};
  endfunction

  // Monitor: datapath model, per-state strobe checks, scoreboard push/pop.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (mdld) md_reg = md_in;
        if (rsclear) rs = '0;
        if (rsload) rs = rs + ({{(W+1){1'b0}}, md_reg} << W);
        if (rsshr) rs = rs >> 1;
        lat_cnt++;
        ctrl_exp = cur_st | (CONST_T ? 1'b0 : cur_mt);
        if (state_dbg == 3'd1) begin
          cur_st = start_t;
          cur_mt = mr_t;
          p_a = {{W{1'b0}}, mr_in};
          p_b = {{W{1'b0}}, md_in};
          e_push.prod = p_a * p_b;
          e_push.lat  = CONST_T ? (2*W + 2) : (2 + W + $countones(mr_in));
          e_push.dt   = start_t | (CONST_T ? 1'b0 : mr_t);
          e_push.pop  = $countones(mr_in);
          sb.push_back(e_push);
          lat_cnt = 1;
          add_cnt = 0;
          accepts++;
          if (held) begin
            if (held_n > 0) check_val("b2b_gap", cyc - last_done_cyc, 2);
            held_n++;
          end
          check_val("load_strb", {ready, mrld, mdld, rsclear, rsload, rsshr, done}, 7'b0111000);
          check_val("load_t", {mrld_t, mdld_t, rsclear_t}, {3{start_t}});
        end
        if (state_dbg == 3'd2) begin
          if (rsload) add_cnt++;
          check_val("add_t", rsload_t, cur_st | cur_mt);
        end
        if (state_dbg == 3'd3) begin
          check_val("shr", {rsshr, rsshr_t, rsload, rsclear}, {1'b1, ctrl_exp, 2'b00});
        end
        if (done) begin
          last_done_cyc = cyc;
          if (sb.size() == 0) begin
            check_val("spur_done", 1, 0);
          end else begin
            e_pop = sb.pop_front();
            check_val("product", rs[2*W-1:0], e_pop.prod);
            check_val("latency", lat_cnt, e_pop.lat);
            check_val("done_t", done_t, e_pop.dt);
            check_val("add_cnt", add_cnt, e_pop.pop);
          end
        end
      end
    end
  end

  task automatic wait_load();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_dbg == 3'd1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_val("load_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_val("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] mr, input logic [W-1:0] md,
                        input logic st, input logic mt);
    @(negedge clk);
    mr_in = mr; md_in = md; start_t = st; mr_t = mt; start = 1'b1;
    wait_load();
    start = 1'b0;
    wait_empty();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nsh;
    int base;
    rst_n = 1'b0; start = 1'b0; start_t = 1'b0; mr_t = 1'b0;
    mr_in = '0; md_in = '0;
    repeat (3) @(negedge clk);
    check_val("reset_out", out_vec(), 16'h8000);
    rst_n = 1'b1;

    run_op(4'd13, 4'd11, 1'b0, 1'b0);
    run_op(4'd0,  4'd15, 1'b0, 1'b0);
    run_op(4'd15, 4'd15, 1'b1, 1'b0);
    @(negedge clk);
    check_val("idle_t_hold", {ready, mrld_t, done_t}, 3'b111);
    run_op(4'd5,  4'd3,  1'b0, 1'b0);
    @(negedge clk);
    check_val("idle_t_clear", {ready, mrld_t, done_t}, 3'b100);
    run_op(4'd13, 4'd11, 1'b0, 1'b1);
    run_op(4'd6,  4'd9,  1'b0, 1'b0);

    // Abort in the SHIFT cycle of bit 2.
    @(negedge clk);
    mr_in = 4'd13; md_in = 4'd11; start_t = 1'b1; mr_t = 1'b0; start = 1'b1;
    wait_load();
    start = 1'b0;
    nsh = 0;
    for (int i = 0; i < 40; i++) begin
      if (state_dbg == 3'd3) nsh++;
      if (nsh == 3) break;
      @(negedge clk);
    end
    check_val("shift2_reached", nsh, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_mid", out_vec(), 16'h8000);
    rst_n = 1'b1;
    sb.delete();
    run_op(4'd3, 4'd5, 1'b0, 1'b0);

    // Start held high across back-to-back operations.
    @(negedge clk);
    mr_in = 4'd9; md_in = 4'd7; start_t = 1'b0; mr_t = 1'b0;
    held_n = 0; held = 1'b1; base = accepts; start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (accepts >= base + 3) break;
    end
    start = 1'b0;
    check_val("held_accepts", accepts - base, 3);
    wait_empty();
    held = 1'b0;

    repeat (3) @(negedge clk);
    check_val("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
